uart_cmd_decoder: RTL

- Downstream of the UART receiver: consumes its one-cycle byte-valid pulse and received byte.
- Assembles 2-byte command frames: byte0 = command code, byte1 = sensor address.
- Validates each frame and presents it to the sensor-control logic over a valid/ready handshake.
- Discards stalled partial frames after an inter-byte timeout and reports every error as a coded pulse.

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_cmd_timeout.sv | 37 +++
 rtl/uart_cmd_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and codes for the UART command path.
// The checksum-wait state exists only when UART_CMD_CHECKSUM_EN is defined.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
`ifdef UART_CMD_CHECKSUM_EN
        S_WAIT_CSUM = 2'd2,
`endif
        S_DISPATCH  = 2'd3
    } state_e;

    localparam logic [7:0] CMD_STATUS   = 8'h00;
    localparam logic [7:0] CMD_TEMP     = 8'h01;
    localparam logic [7:0] CMD_HUM      = 8'h02;
    localparam logic [7:0] CMD_CONT_ON  = 8'h03;
    localparam logic [7:0] CMD_CONT_OFF = 8'h04;
    localparam logic [7:0] CMD_MAX      = CMD_CONT_OFF;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CMD     = 3'd1;
    localparam logic [2:0] ERR_ADDR    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;
    localparam logic [2:0] ERR_CSUM    = 3'd5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable, clearable saturating down-counter; expire_o flags a zero count while enabled.
module uart_cmd_timeout #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles command/address frames from UART bytes, validates them and hands them off via valid/ready.
// Define UART_CMD_CHECKSUM_EN for 3-byte frames whose last byte is the XOR of the first two.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 6950,
    parameter int TIMEOUT_BITS = 20,
    parameter int NUM_ADDR     = 32
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Cmd_Valid,
    output logic [7:0] o_Cmd,
    output logic [7:0] o_Addr,
    input  logic       i_Cmd_Ready,
    output logic       o_Err_Pulse,
    output logic [2:0] o_Err_Code,
    output logic       o_Busy
);

    localparam int TIMEOUT_CYCLES = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry is decided one cycle before the registered error pulse, so the
    // pulse lands exactly TIMEOUT_CYCLES after the last accepted byte.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 2);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic       err_pulse_q, err_pulse_d;
    logic [2:0] err_code_q, err_code_d;
    logic [2:0] frame_err;
    logic       to_load, to_clr, to_run, to_expire;

    function automatic logic [2:0] check_frame(input logic [7:0] cmd, input logic [7:0] addr);
        logic [2:0] code;
        code = ERR_NONE;
        if ({1'b0, addr} >= 9'(NUM_ADDR)) code = ERR_ADDR;
        if (cmd > CMD_MAX)                code = ERR_CMD;
        return code;
    endfunction

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        frame_err   = ERR_NONE;
        to_load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    cmd_d   = i_Rx_Byte;
                    to_load = 1'b1;
                    state_d = S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d = i_Rx_Byte;
`ifdef UART_CMD_CHECKSUM_EN
                    to_load = 1'b1;
                    state_d = S_WAIT_CSUM;
`else
                    frame_err = check_frame(cmd_q, i_Rx_Byte);
                    state_d   = (frame_err == ERR_NONE) ? S_DISPATCH : S_IDLE;
`endif
                end else if (to_expire) begin
                    frame_err = ERR_TIMEOUT;
                    state_d   = S_IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_WAIT_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != (cmd_q ^ addr_q)) begin
                        frame_err = ERR_CSUM;
                    end else begin
                        frame_err = check_frame(cmd_q, addr_q);
                    end
                    state_d = (frame_err == ERR_NONE) ? S_DISPATCH : S_IDLE;
                end else if (to_expire) begin
                    frame_err = ERR_TIMEOUT;
                    state_d   = S_IDLE;
                end
            end
`endif
            S_DISPATCH: begin
                if (i_Cmd_Ready) state_d = S_IDLE;
                // Any byte arriving while a frame is held is dropped, even on the transfer edge.
                if (i_Rx_DV) frame_err = ERR_OVERRUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (frame_err != ERR_NONE) begin
            err_pulse_d = 1'b1;
            err_code_d  = frame_err;
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    assign to_run = (state_q == S_WAIT_ADDR) || (state_q == S_WAIT_CSUM);
`else
    assign to_run = (state_q == S_WAIT_ADDR);
`endif
    assign to_clr = (state_d == S_IDLE);

    uart_cmd_timeout #(
        .WIDTH (TO_W)
    ) u_timeout (
        .clk_i      (i_Clock),
        .rst_ni     (i_Rst_n),
        .load_i     (to_load),
        .load_val_i (TO_LOAD),
        .clr_i      (to_clr),
        .en_i       (to_run),
        .expire_o   (to_expire)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    assign o_Cmd_Valid = (state_q == S_DISPATCH);
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Cmd       = cmd_q;
    assign o_Addr      = addr_q;
    assign o_Err_Pulse = err_pulse_q;
    assign o_Err_Code  = err_code_q;

endmodule
